pulse_burst_controller: RTL and testbench



---
 rtl/pulse_pkg.sv | 24 ++
 rtl/pulse_phase_counter.sv | 41 ++++
 rtl/pulse_burst_controller.sv | 170 +++++++++++++++++
 tb/tb_pulse_burst_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse burst sequencer.
// CONTINUOUS_MODE_EN (optional) accepts a zero pulse count as an endless train.
package pulse_pkg;

  localparam int WIDTH_W_DEF = 16;
  localparam int COUNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_FIN
  } pulse_state_e;

  function automatic logic cfg_valid(
    input logic [31:0] w,
    input logic [31:0] p,
    input logic [31:0] n,
    input logic        allow_zero_n
  );
    return (w != '0) && (w < p) && (allow_zero_n || (n != '0));
  endfunction

endpackage

// File: rtl/pulse_phase_counter.sv
// Loadable down-counter with a terminal (zero) flag.
// Clear has priority over load, load over decrement; holds at zero.
module pulse_phase_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr_i:  cnt_d = '0;
      load_i: cnt_d = load_val_i;
      default: begin
        if (dec_i && (cnt_q != '0)) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_burst_controller.sv
// Pulse burst sequencer: latched config, cycle-exact HIGH/LOW phases, status.
// Optional CONTINUOUS_MODE_EN: CFG_COUNT=0 starts an endless train.
module pulse_burst_controller
  import pulse_pkg::*;
#(
  parameter int WIDTH_W = WIDTH_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               CLOCK_50MHZ,
  input  logic               RST_N,
  input  logic               START,
  input  logic               ABORT,
  input  logic [WIDTH_W-1:0] CFG_WIDTH,
  input  logic [WIDTH_W-1:0] CFG_PERIOD,
  input  logic [COUNT_W-1:0] CFG_COUNT,
  output logic               PULSE_OUT,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [COUNT_W-1:0] PULSE_IDX
);

`ifdef CONTINUOUS_MODE_EN
  localparam logic ContEn = 1'b1;
`else
  localparam logic ContEn = 1'b0;
`endif

  pulse_state_e state_q, state_d;

  logic [WIDTH_W-1:0] w_q, p_q;
  logic [COUNT_W-1:0] n_q;
  logic               latch_en;

  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] idx_q, idx_d;

  logic               cnt_clr;
  logic               cnt_load;
  logic [WIDTH_W-1:0] cnt_val;
  logic               cnt_dec;
  logic               cnt_zero;

  logic               cfg_ok;
  logic               endless;
  logic               last_pulse;

  assign cfg_ok = cfg_valid(32'(CFG_WIDTH), 32'(CFG_PERIOD),
                            32'(CFG_COUNT), ContEn);
  assign endless    = ContEn && (n_q == '0);
  assign last_pulse = !endless && (idx_q == n_q - 1'b1);

  pulse_phase_counter #(
    .W(WIDTH_W)
  ) u_phase (
    .clk_i      (CLOCK_50MHZ),
    .rst_ni     (RST_N),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = 1'b0;
    latch_en = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (cfg_ok) begin
            latch_en = 1'b1;
            state_d  = ST_HIGH;
            idx_d    = '0;
            cnt_load = 1'b1;
            cnt_val  = CFG_WIDTH - 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (ABORT) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_zero) begin
          state_d  = ST_LOW;
          cnt_load = 1'b1;
          cnt_val  = p_q - w_q - 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_LOW: begin
        if (ABORT) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_zero) begin
          if (last_pulse) begin
            state_d = ST_FIN;
          end else begin
            state_d  = ST_HIGH;
            idx_d    = idx_q + 1'b1;
            cnt_load = 1'b1;
            cnt_val  = w_q - 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pulse_d = (state_d == ST_HIGH);
    busy_d  = (state_d == ST_HIGH) || (state_d == ST_LOW);
    done_d  = (state_d == ST_FIN);
  end

  always_ff @(posedge CLOCK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge CLOCK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      w_q <= '0;
      p_q <= '0;
      n_q <= '0;
    end else if (latch_en) begin
      w_q <= CFG_WIDTH;
      p_q <= CFG_PERIOD;
      n_q <= CFG_COUNT;
    end
  end

  assign PULSE_OUT = pulse_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign PULSE_IDX = idx_q;

endmodule

// File: tb/tb_pulse_burst_controller.sv
// Bench for pulse_burst_controller: directed plan plus random traffic
// against a timeline model (offset k since acceptance -> outputs).
module tb_pulse_burst_controller;

  localparam int WW = 16;
`ifdef CONTINUOUS_MODE_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [WW-1:0] cfg_w;
  logic [WW-1:0] cfg_p;
  logic [CW-1:0] cfg_n;
  logic          pulse_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] pulse_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pulse_burst_controller #(
    .WIDTH_W(WW),
    .COUNT_W(CW)
  ) dut (
    .CLOCK_50MHZ (clk),
    .RST_N       (rst_n),
    .START       (start),
    .ABORT       (abort),
    .CFG_WIDTH   (cfg_w),
    .CFG_PERIOD  (cfg_p),
    .CFG_COUNT   (cfg_n),
    .PULSE_OUT   (pulse_out),
    .BUSY        (busy),
    .DONE        (done),
    .ERR         (err),
    .PULSE_IDX   (pulse_idx)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference: 0 idle, 1 burst, 2 fin cycle
  int      m_mode;
  longint  m_k;
  int      m_w, m_p, m_n;
  bit      m_endless;
  bit      e_pulse, e_busy, e_done, e_err;
  int      e_idx;

  function automatic bit ref_valid(int w, int p, int n);
`ifdef CONTINUOUS_MODE_EN
    return (w != 0) && (w < p);
`else
    return (w != 0) && (w < p) && (n != 0);
`endif
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_k     = 0;
    e_pulse = 0;
    e_busy  = 0;
    e_done  = 0;
    e_err   = 0;
    e_idx   = 0;
  endtask

  task automatic model_edge();
    e_done = 0;
    e_err  = 0;
    case (m_mode)
      1: begin
        if (abort) begin
          m_mode  = 0;
          e_pulse = 0;
          e_busy  = 0;
        end else begin
          m_k++;
          if (!m_endless && m_k > longint'(m_n) * m_p) begin
            m_mode  = 2;
            e_pulse = 0;
            e_busy  = 0;
            e_done  = 1;
          end else begin
            e_pulse = ((m_k - 1) % m_p) < m_w;
            e_idx   = int'(((m_k - 1) / m_p) % (longint'(1) << CW));
          end
        end
      end
      2: m_mode = 0;
      default: begin
        if (start) begin
          if (ref_valid(int'(cfg_w), int'(cfg_p), int'(cfg_n))) begin
            m_w       = int'(cfg_w);
            m_p       = int'(cfg_p);
            m_n       = int'(cfg_n);
            m_endless = (m_n == 0);
            m_mode    = 1;
            m_k       = 1;
            e_pulse   = 1;
            e_busy    = 1;
            e_idx     = 0;
          end else begin
            e_err = 1;
          end
        end
      end
    endcase
  endtask

  task automatic check_all(input string ph);
    check({ph, ".pulse"}, 32'(pulse_out), 32'(e_pulse));
    check({ph, ".busy"},  32'(busy),      32'(e_busy));
    check({ph, ".done"},  32'(done),      32'(e_done));
    check({ph, ".err"},   32'(err),       32'(e_err));
    check({ph, ".idx"},   32'(pulse_idx), 32'(e_idx));
  endtask

  task automatic cycle(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic run(input string ph, input int n);
    for (int i = 0; i < n; i++) cycle(ph);
  endtask

  task automatic set_cfg(input int w, input int p, input int n);
    cfg_w = WW'(w);
    cfg_p = WW'(p);
    cfg_n = CW'(n);
  endtask

  task automatic pulse_start(input string ph);
    start = 1'b1;
    cycle(ph);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    set_cfg(0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run("idle", 2);

    // Basic burst W=2 P=5 N=3
    set_cfg(2, 5, 3);
    pulse_start("b253");
    run("b253", 18);

    // Rejected configs
    set_cfg(5, 5, 1);
    pulse_start("rej_wp");
    run("rej_wp", 2);
    set_cfg(0, 4, 1);
    pulse_start("rej_w0");
    run("rej_w0", 2);
`ifndef CONTINUOUS_MODE_EN
    set_cfg(2, 4, 0);
    pulse_start("rej_n0");
    run("rej_n0", 2);
`endif

    // Abort during pulse 2 LOW phase
    set_cfg(3, 8, 4);
    pulse_start("abort");
    run("abort", 12);
    abort = 1'b1;
    cycle("abort");
    abort = 1'b0;
    check("abort.idx1", 32'(pulse_idx), 32'd1);
    run("abort", 4);

    // START held through FIN, width changed mid-burst
    set_cfg(2, 5, 2);
    start = 1'b1;
    run("held", 3);
    cfg_w = WW'(6);
    run("held", 14);
    start = 1'b0;
    run("held", 12);

    // Boundaries: single-cycle LOW, minimum period
    set_cfg(3, 4, 2);
    pulse_start("bnd34");
    run("bnd34", 10);
    set_cfg(1, 2, 3);
    pulse_start("bnd12");
    run("bnd12", 8);

    // Async reset during HIGH
    set_cfg(4, 10, 2);
    pulse_start("rst");
    run("rst", 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    run("rst_idle", 4);

`ifdef CONTINUOUS_MODE_EN
    set_cfg(1, 2, 0);
    pulse_start("cont");
    run("cont", 11);
    check("cont.busy", 32'(busy), 32'd1);
    abort = 1'b1;
    cycle("cont_ab");
    abort = 1'b0;
    run("cont_ab", 3);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(3) == 0);
      abort = ($urandom_range(24) == 0);
      set_cfg(int'($urandom_range(5)), int'($urandom_range(8)),
              int'($urandom_range(4)));
      cycle("rnd");
    end
    start = 1'b0;
    abort = 1'b1;
    run("rnd_end", 2);
    abort = 1'b0;
    run("rnd_end", 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
